// File: rtl/picorv32_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : picorv32_mem_pkg
//  Description : Shared types and constants for the picorv32 memory responder:
//                FSM state encoding and bit positions of the sticky error flags.
//  Revision    : 1.0 - initial release
// ============================================================================
package picorv32_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int ERR_PROTO = 2;
  localparam int ERR_RANGE = 1;
  localparam int ERR_ALIGN = 0;

endpackage
`default_nettype wire

// File: rtl/mem_byte_ram.sv
`default_nettype none
// ============================================================================
//  Module      : mem_byte_ram
//  Description : 2**MEM_WORDS_LOG2 x 32 RAM built from four byte lanes.
//                Asynchronous read. Port A commits strobed bytes, port B writes
//                a full word (preload). The two ports are never active together
//                because the owner only enables them in disjoint FSM states.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_byte_ram #(
  parameter int MEM_WORDS_LOG2 = 10
) (
  input  logic                      clk,
  input  logic                      a_we,
  input  logic [MEM_WORDS_LOG2-1:0] a_addr,
  input  logic [3:0]                a_wstrb,
  input  logic [31:0]               a_wdata,
  input  logic                      b_we,
  input  logic [MEM_WORDS_LOG2-1:0] b_addr,
  input  logic [31:0]               b_wdata,
  input  logic [MEM_WORDS_LOG2-1:0] rd_addr,
  output logic [31:0]               rd_data
);

  localparam int c_DEPTH = 1 << MEM_WORDS_LOG2;

  for (genvar lane = 0; lane < 4; lane++) begin : g_lane
    logic [7:0] r_bytes [c_DEPTH];

    // Byte-lane storage: full-word backdoor write wins, else strobed commit
    always_ff @(posedge clk) begin
      if (b_we) begin
        r_bytes[b_addr] <= b_wdata[8*lane +: 8];
      end else if (a_we && a_wstrb[lane]) begin
        r_bytes[a_addr] <= a_wdata[8*lane +: 8];
      end
    end

    assign rd_data[8*lane +: 8] = r_bytes[rd_addr];
  end

endmodule
`default_nettype wire

// File: rtl/picorv32_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : picorv32_mem_responder
//  Description : Memory-side responder for the picorv32 native interface.
//                Accepts one request at a time, waits wait_cfg cycles, then
//                pulses mem_ready. Reads are overlaid with a pinned instruction
//                halfword; initiator misbehaviour is recorded in sticky flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module picorv32_mem_responder
  import picorv32_mem_pkg::*;
#(
  parameter int MEM_WORDS_LOG2 = 10,
  parameter int WAIT_W         = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      mem_valid,
  input  logic                      mem_instr,
  input  logic [31:0]               mem_addr,
  input  logic [31:0]               mem_wdata,
  input  logic [3:0]                mem_wstrb,
  output logic                      mem_ready,
  output logic [31:0]               mem_rdata,
  input  logic [WAIT_W-1:0]         wait_cfg,
  input  logic [31:0]               imem_addr,
  input  logic [15:0]               imem_data,
  input  logic                      init_we,
  input  logic [MEM_WORDS_LOG2-1:0] init_addr,
  input  logic [31:0]               init_data,
  output logic [2:0]                err
);

  // Byte-address width covered by the RAM; anything with higher bits set is out of range
  localparam int c_ADDR_W = MEM_WORDS_LOG2 + 2;

  state_t              r_state;
  state_t              w_next;
  logic [31:0]         r_addr;
  logic [31:0]         r_wdata;
  logic [3:0]          r_wstrb;
  logic [WAIT_W-1:0]   r_cnt;
  logic                r_ready;
  logic [2:0]          r_err;

  logic                w_accept;
  logic                w_init_we;
  logic                w_req_oob;
  logic                w_in_range;
  logic                w_busy;
  logic                w_proto;
  logic                w_commit;
  logic [31:0]         w_ram_rd;
  logic [31:0]         w_rdata;

  // mem_instr is informational only; it deliberately has no effect on behaviour
  logic                w_unused;
  assign w_unused = &{1'b0, mem_instr};

  // Backdoor preload owns the IDLE cycle, so a simultaneous request waits one cycle
  assign w_init_we  = init_we && (r_state == IDLE);
  assign w_accept   = (r_state == IDLE) && mem_valid && !init_we;
  assign w_req_oob  = |mem_addr[31:c_ADDR_W];
  assign w_in_range = ~|r_addr[31:c_ADDR_W];
  assign w_busy     = (r_state == WAIT) || (r_state == RESP);
  assign w_proto    = w_busy && (!mem_valid || (mem_addr != r_addr) ||
                                 (mem_wdata != r_wdata) || (mem_wstrb != r_wstrb));
  // Commit on the edge that ends RESP; a reset on that edge aborts the write
  assign w_commit   = (r_state == RESP) && (r_wstrb != 4'b0000) && w_in_range && !reset;

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (w_accept) w_next = (wait_cfg == '0) ? RESP : WAIT;
      WAIT: if (r_cnt == WAIT_W'(1)) w_next = RESP;
      RESP: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Request latches; the initiator's later changes are ignored once accepted
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_addr  <= mem_addr;
      r_wdata <= mem_wdata;
      r_wstrb <= mem_wstrb;
    end
  end

  // Wait-state counter and registered ready pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt   <= '0;
      r_ready <= 1'b0;
    end else begin
      if (w_accept)                r_cnt <= wait_cfg;
      else if (r_state == WAIT)    r_cnt <= r_cnt - WAIT_W'(1);
      r_ready <= (w_next == RESP);
    end
  end

  // Sticky violation flags
  always_ff @(posedge clk) begin
    if (reset) begin
      r_err <= '0;
    end else begin
      if (w_accept && w_req_oob)           r_err[ERR_RANGE] <= 1'b1;
      if (w_accept && (mem_addr[1:0] != 2'b00)) r_err[ERR_ALIGN] <= 1'b1;
      if (w_proto)                         r_err[ERR_PROTO] <= 1'b1;
    end
  end

  mem_byte_ram #(
    .MEM_WORDS_LOG2(MEM_WORDS_LOG2)
  ) u_ram (
    .clk     (clk),
    .a_we    (w_commit),
    .a_addr  (r_addr[c_ADDR_W-1:2]),
    .a_wstrb (r_wstrb),
    .a_wdata (r_wdata),
    .b_we    (w_init_we),
    .b_addr  (init_addr),
    .b_wdata (init_data),
    .rd_addr (r_addr[c_ADDR_W-1:2]),
    .rd_data (w_ram_rd)
  );

  // Read data: RAM word with the pinned halfword laid over it, zero otherwise
  always_comb begin
    w_rdata = '0;
    if (r_ready && (r_wstrb == 4'b0000) && w_in_range) begin
      w_rdata = w_ram_rd;
      if (r_addr == imem_addr)          w_rdata[15:0]  = imem_data;
      if ((r_addr + 32'd2) == imem_addr) w_rdata[31:16] = imem_data;
    end
  end

  assign mem_ready = r_ready;
  assign mem_rdata = w_rdata;
  assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_picorv32_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_picorv32_mem_responder
//  Description : Self-checking bench for picorv32_mem_responder. A driver
//                issues requests and pushes expected responses into a queue;
//                a monitor pops and compares on every mem_ready pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_picorv32_mem_responder;

  localparam int MW    = 10;
  localparam int WW    = 2;
  localparam int DEPTH = 1 << MW;
  localparam logic [31:0] LIMIT = 32'(4 * DEPTH);

  logic          clk = 1'b0;
  logic          reset;
  logic          mem_valid, mem_instr;
  logic [31:0]   mem_addr, mem_wdata;
  logic [3:0]    mem_wstrb;
  logic          mem_ready;
  logic [31:0]   mem_rdata;
  logic [WW-1:0] wait_cfg;
  logic [31:0]   imem_addr;
  logic [15:0]   imem_data;
  logic          init_we;
  logic [MW-1:0] init_addr;
  logic [31:0]   init_data;
  logic [2:0]    err;

  picorv32_mem_responder #(.MEM_WORDS_LOG2(MW), .WAIT_W(WW)) dut (
    .clk(clk), .reset(reset), .mem_valid(mem_valid), .mem_instr(mem_instr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .wait_cfg(wait_cfg),
    .imem_addr(imem_addr), .imem_data(imem_data), .init_we(init_we),
    .init_addr(init_addr), .init_data(init_data), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: word array, sticky error flags, expected-response queue
  logic [31:0] model_mem [DEPTH];
  logic [2:0]  model_err;
  typedef struct { logic [31:0] rdata; int cyc; logic [2:0] err; } exp_t;
  exp_t sbq[$];

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic logic [31:0] ref_read(logic [31:0] a);
    logic [31:0] w;
    if (a >= LIMIT) return 32'h0;
    w = model_mem[a[MW+1:2]];
    if (a == imem_addr)         w[15:0]  = imem_data;
    if (a + 32'd2 == imem_addr) w[31:16] = imem_data;
    return w;
  endfunction

  // Monitor: every ready pulse must match the oldest expected response
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (mem_ready) begin
        if (sbq.size() == 0) begin
          check("unexpected_ready", 32'd1, 32'd0);
        end else begin
          e = sbq.pop_front();
          check("rdata", mem_rdata, e.rdata);
          check("latency", 32'(cyc), 32'(e.cyc));
          check("err", 32'(err), 32'(e.err));
        end
      end else if (mem_rdata != 32'h0) begin
        check("rdata_idle", mem_rdata, 32'h0);
      end
    end
  end

  task automatic init_word(input logic [MW-1:0] ia, input logic [31:0] d);
    @(negedge clk);
    init_we = 1'b1; init_addr = ia; init_data = d;
    model_mem[ia] = d;
    @(negedge clk);
    init_we = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; mem_valid = 1'b0; init_we = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(mem_ready), 32'd0);
    check("rst_rdata", mem_rdata, 32'h0);
    check("rst_err", 32'(err), 32'd0);
    reset = 1'b0;
    model_err = 3'b000;
  endtask

  // Issue one transaction; optionally collide with a preload or drop mem_valid in WAIT
  task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                       input int w, input bit drop, input bit coll,
                       input logic [MW-1:0] ia, input logic [31:0] id);
    exp_t e;
    int   c0;
    int   t;
    @(negedge clk);
    mem_valid = 1'b1; mem_addr = a; mem_wdata = d; mem_wstrb = s;
    wait_cfg = WW'(w); mem_instr = 1'($urandom);
    c0 = cyc;
    if (coll) begin
      init_we = 1'b1; init_addr = ia; init_data = id;
      model_mem[ia] = id;
      c0 = c0 + 1;
    end
    if (a >= LIMIT)      model_err[1] = 1'b1;
    if (a[1:0] != 2'b00) model_err[0] = 1'b1;
    if (drop)            model_err[2] = 1'b1;
    e.rdata = (s == 4'b0000) ? ref_read(a) : 32'h0;
    if (s != 4'b0000 && a < LIMIT)
      for (int b = 0; b < 4; b++)
        if (s[b]) model_mem[a[MW+1:2]][8*b +: 8] = d[8*b +: 8];
    e.cyc = c0 + 1 + w;
    e.err = model_err;
    sbq.push_back(e);
    if (coll) begin
      @(negedge clk);
      init_we = 1'b0;
    end
    if (drop) begin
      @(negedge clk);
      mem_valid = 1'b0;
      @(negedge clk);
      mem_valid = 1'b1;
    end
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!mem_ready && t < 20);
    if (!mem_ready) begin
      check("ready_timeout", 32'd0, 32'd1);
      sbq.delete();
    end
    @(posedge clk);
    #1;
    mem_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    logic [3:0]  s;
    int          w, r;
    bit          drop, coll;

    reset = 1'b1; mem_valid = 1'b0; mem_instr = 1'b0; mem_addr = '0;
    mem_wdata = '0; mem_wstrb = '0; wait_cfg = '0; imem_addr = 32'hFFFF_FFF0;
    imem_data = '0; init_we = 1'b0; init_addr = '0; init_data = '0;
    model_err = 3'b000;
    do_reset();

    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      init_we = 1'b1; init_addr = MW'(i); init_data = $urandom;
      model_mem[i] = init_data;
    end
    @(negedge clk);
    init_we = 1'b0;

    // Read with two wait states, then partial-strobe write and read-back
    init_word(MW'(5), 32'h1122_3344);
    issue(32'h14, 32'h0, 4'b0000, 2, 0, 0, '0, '0);
    issue(32'h14, 32'hAABB_CCDD, 4'b0101, 0, 0, 0, '0, '0);
    issue(32'h14, 32'h0, 4'b0000, 1, 0, 0, '0, '0);
    check("merged_word", model_mem[5], 32'h11BB_33DD);

    // Pinned halfword overlays both halves of the neighbouring words
    imem_addr = 32'h102; imem_data = 16'hBEEF;
    init_word(MW'(32'h40), 32'h0);
    issue(32'h100, 32'h0, 4'b0000, 1, 0, 0, '0, '0);
    issue(32'h102, 32'h0, 4'b0000, 0, 0, 0, '0, '0);
    issue(32'h100, 32'h5555_6666, 4'b1111, 0, 0, 0, '0, '0);
    issue(32'h100, 32'h0, 4'b0000, 3, 0, 0, '0, '0);

    // Out-of-range then misaligned
    do_reset();
    issue(32'h2000, 32'h0, 4'b0000, 1, 0, 0, '0, '0);
    issue(32'h3, 32'h0, 4'b0000, 0, 0, 0, '0, '0);
    issue(32'h2000, 32'hFFFF_FFFF, 4'b1111, 0, 0, 0, '0, '0);

    // Protocol violation, then reset aborting a pending write
    do_reset();
    issue(32'h40, 32'h0, 4'b0000, 3, 1, 0, '0, '0);
    @(negedge clk);
    mem_valid = 1'b1; mem_addr = 32'h40; mem_wdata = ~model_mem[16];
    mem_wstrb = 4'b1111; wait_cfg = WW'(3);
    @(negedge clk);
    reset = 1'b1; mem_valid = 1'b0;
    @(negedge clk);
    check("abort_ready", 32'(mem_ready), 32'd0);
    check("abort_err", 32'(err), 32'd0);
    reset = 1'b0;
    model_err = 3'b000;
    issue(32'h40, 32'h0, 4'b0000, 0, 0, 0, '0, '0);

    // Preload colliding with a request defers acceptance by one cycle
    issue(32'h80, 32'h0, 4'b0000, 1, 0, 1, MW'(32'h20), 32'hCAFE_F00D);
    issue(32'h84, 32'h0, 4'b0000, 0, 0, 1, MW'(32'h21), 32'h0BAD_BEEF);

    // Randomized traffic
    do_reset();
    for (int k = 0; k < 300; k++) begin
      r = $urandom_range(0, 99);
      if (r < 60)      a = 32'($urandom_range(0, DEPTH - 1)) << 2;
      else if (r < 75) a = imem_addr + 32'($urandom_range(0, 2)) * 32'd2 - 32'd2;
      else if (r < 85) a = $urandom | 32'h0000_1000;
      else             a = (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
      s    = $urandom_range(0, 1) ? 4'($urandom) : 4'b0000;
      w    = $urandom_range(0, 3);
      coll = ($urandom_range(0, 9) == 0);
      drop = !coll && (w == 3) && ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 19) == 0) begin
        imem_addr = 32'($urandom_range(0, 2047)) * 32'd2;
        imem_data = 16'($urandom);
      end
      issue(a, $urandom, s, w, drop, coll, MW'($urandom), $urandom);
    end

    repeat (5) @(negedge clk);
    check("sb_empty", 32'(sbq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
